// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes, FSM encoding and clear bound for the register bank
package regbank_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] CLR_LAST = 4'd15;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/regbank_write_if.sv
// regbank_write_if: valid/ready write port (wr_valid, wr_ready, wr_addr, wr_data); master drives, slave accepts
interface regbank_write_if
  import regbank_pkg::*;
#(parameter int DATA_W = 32);
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master(output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/regbank_write_dec4_to_16.sv
// dec4_to_16: one-hot decoder; addr_i/en_i in, onehot_o out (all zero when en_i is low)
module dec4_to_16
  import regbank_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);
  assign onehot_o = en_i ? {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_i : '0;
endmodule

// File: rtl/regbank_write.sv
// regbank_write: 16-entry register bank write side with valid/ready port and sequential clear engine
// ports: clk, rst_n (async active-low), wr (write port slave), clr_req, busy, clr_done, q (flat register bus), written
// option: REGBANK_R0_ZERO_EN makes register 0 a constant zero
module regbank_write
  import regbank_pkg::*;
#(parameter int DATA_W = 32) (
  input  logic                       clk,
  input  logic                       rst_n,
  regbank_write_if.slave             wr,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       clr_done,
  output logic [NUM_REGS*DATA_W-1:0] q,
  output logic [NUM_REGS-1:0]        written
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] written_q, dec_en, wr_en;
  logic [DATA_W-1:0] wdata;
  logic clr, fire;
  assign clr = state_q == CLEAR;
  assign wr.wr_ready = !clr && !clr_req;
  assign fire = wr.wr_valid && wr.wr_ready;
  assign busy = clr;
  assign clr_done = clr && cnt_q == CLR_LAST;
  // the clear engine reuses the write decoder, driving cnt as address and zero as data
  assign wdata = clr ? '0 : wr.wr_data;
  dec4_to_16 u_dec (
    .addr_i  (clr ? cnt_q : wr.wr_addr),
    .en_i    (clr || fire),
    .onehot_o(dec_en)
  );
`ifdef REGBANK_R0_ZERO_EN
  // address 0 still handshakes but never updates, so reg 0 and written[0] stay at their reset zero
  assign wr_en = dec_en & {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
  assign wr_en = dec_en;
`endif
  always_comb begin
    state_d = clr ? (cnt_q == CLR_LAST ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    cnt_d = clr ? cnt_q + 4'd1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q <= '{default: '0};
      written_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en[i]) begin
          regs_q[i] <= wdata;
          written_q[i] <= !clr;
        end
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign q[i*DATA_W +: DATA_W] = regs_q[i];
  end
  assign written = written_q;
endmodule
